// File: rtl/mont_mult_seq.sv
// Sequential radix-2 Montgomery multiplier: y = a*b*2^-NBITS mod m, one bit of a per cycle.
// Single NBITS+2 adder pair; start/done handshake with even-modulus error reporting.
module mont_mult_seq #(
  parameter int NBITS = 2048,
  parameter int CNT_W = $clog2(NBITS) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] b,
  input  logic [NBITS-1:0] m,
  output logic [NBITS-1:0] y,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, LOOP, REDUCE, FIN} state_t;

  state_t           state_q, state_d;
  logic [NBITS-1:0] a_q, a_d, b_q, b_d, m_q, m_d, y_q, y_d;
  logic [NBITS+1:0] t_q, t_d;
  logic [NBITS+1:0] u1, u2;
  logic [NBITS-1:0] y_sub;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d, err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      y_q     <= '0;
      t_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      y_q     <= y_d;
      t_q     <= t_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = m[0] ? LOOP : FIN;
      LOOP:    if (cnt_q == CNT_W'(NBITS - 1)) state_d = REDUCE;
      REDUCE:  state_d = FIN;
      default: state_d = IDLE;
    endcase
  end

  // a_q is shifted right each iteration so the current multiplier bit is always a_q[0].
  // t < 2m keeps t + b + m below 4m, so NBITS+2 bits never overflow.
  always_comb begin
    u1    = t_q + ({(NBITS+2){a_q[0]}} & {2'b00, b_q});
    u2    = u1 + ({(NBITS+2){u1[0]}} & {2'b00, m_q});
    y_sub = t_q[NBITS-1:0] - m_q;
  end

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    m_d    = m_q;
    y_d    = y_q;
    t_d    = t_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    err_d  = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d    = a;
          b_d    = b;
          m_d    = m;
          t_d    = '0;
          cnt_d  = '0;
          busy_d = 1'b1;
          err_d  = 1'b0;
          if (!m[0]) y_d = '0;
        end
      end
      LOOP: begin
        t_d   = u2 >> 1;
        a_d   = a_q >> 1;
        cnt_d = cnt_q + CNT_W'(1);
      end
      REDUCE: begin
        y_d = (t_q >= {2'b00, m_q}) ? y_sub : t_q[NBITS-1:0];
      end
      default: begin
        done_d = 1'b1;
        busy_d = 1'b0;
        err_d  = ~m_q[0];
      end
    endcase
  end

  assign y    = y_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule
